// File: rtl/gpio_seq_pkg.sv
// Shared types and pattern generation for the GPIO output sequencer.
// The BOUNCE table is indexed by a dedicated 0..5 phase counter.
package gpio_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam int unsigned BOUNCE_LEN = 6;

  // Entry 0 sits in the least significant nibble.
  localparam logic [23:0] BOUNCE_LUT = {4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

  function automatic logic [3:0] step_pattern(mode_e mode, logic [3:0] idx, logic [2:0] phase);
    logic [3:0] pat;
    pat = 4'h0;
    case (mode)
      MODE_WALK:   pat = 4'b0001 << idx[1:0];
      MODE_BOUNCE: pat = BOUNCE_LUT[{phase, 2'b00} +: 4];
      MODE_BLINK:  pat = idx[0] ? 4'h0 : 4'hF;
      MODE_COUNT:  pat = idx;
      default:     pat = 4'h0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/gpio_seq_prescaler.sv
// Step-rate divider: after load, tick fires once every prescale+1 cycles until cleared.
module gpio_seq_prescaler
  import gpio_seq_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] limit_q;
  logic                  active_q;

  assign tick = active_q && (cnt_q == limit_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      limit_q  <= '0;
      active_q <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      limit_q  <= prescale;
      active_q <= 1'b1;
    end else if (active_q) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_out_sequencer.sv
// Board GPIO driver: passes CPU_GPIO through in IDLE, plays a latched
// pattern (WALK/BOUNCE/BLINK/COUNT) in RUN; BUSY mirrors the FSM state.
module gpio_out_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int STEP_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [3:0]            CPU_GPIO,
  input  logic                  PAT_START,
  input  logic                  PAT_STOP,
  input  logic [1:0]            PAT_MODE,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [STEP_W-1:0]     STEP_CNT,
  output logic [3:0]            GPIO_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [STEP_W-1:0] STEP_ONE = 1;

  // Control semantics: PAT_START is a level sampled each edge and acted on only
  // in IDLE; PAT_STOP acts only in RUN but also vetoes a same-edge start in IDLE.
  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [2:0]         phase_q, phase_d;
  logic [3:0]         gpio_q, gpio_d;
  logic               done_q, done_d;
  logic               load, clear, tick, last_step;

  gpio_seq_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (CLK),
    .resetn   (RESETn),
    .load     (load),
    .clear    (clear),
    .prescale (PRESCALE),
    .tick     (tick)
  );

  // STEP_CNT of zero disables self-termination; the index then simply wraps.
  assign last_step = (steps_q != '0) && (step_q == steps_q - STEP_ONE);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    steps_d = steps_q;
    step_d  = step_q;
    phase_d = phase_q;
    gpio_d  = gpio_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gpio_d = CPU_GPIO;
        clear  = 1'b1;
        if (PAT_START && !PAT_STOP) begin
          state_d = ST_RUN;
          load    = 1'b1;
          clear   = 1'b0;
          mode_d  = mode_e'(PAT_MODE);
          steps_d = STEP_CNT;
          step_d  = '0;
          phase_d = 3'd0;
          gpio_d  = step_pattern(mode_e'(PAT_MODE), 4'h0, 3'd0);
        end
      end
      ST_RUN: begin
        if (PAT_STOP || (tick && last_step)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          gpio_d  = CPU_GPIO;
          clear   = 1'b1;
        end else if (tick) begin
          step_d  = step_q + STEP_ONE;
          phase_d = (phase_q == 3'(BOUNCE_LEN - 1)) ? 3'd0 : phase_q + 3'd1;
          gpio_d  = step_pattern(mode_q, 4'(step_d), phase_d);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WALK;
      steps_q <= '0;
      step_q  <= '0;
      phase_q <= 3'd0;
      gpio_q  <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      gpio_q  <= gpio_d;
      done_q  <= done_d;
    end
  end

  assign GPIO_OUT = gpio_q;
  assign BUSY     = (state_q == ST_RUN);
  assign DONE     = done_q;

endmodule

// File: tb/tb_gpio_out_sequencer.sv
// Self-checking bench for gpio_out_sequencer: directed table, hand sequences
// and randomized runs against a sequence-level reference model.
module tb_gpio_out_sequencer;

  logic        clk;
  logic        resetn;
  logic [3:0]  cpu_gpio;
  logic        pat_start;
  logic        pat_stop;
  logic [1:0]  pat_mode;
  logic [15:0] prescale;
  logic [7:0]  step_cnt;
  logic [3:0]  gpio_out;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  gpio_out_sequencer dut (
    .CLK       (clk),
    .RESETn    (resetn),
    .CPU_GPIO  (cpu_gpio),
    .PAT_START (pat_start),
    .PAT_STOP  (pat_stop),
    .PAT_MODE  (pat_mode),
    .PRESCALE  (prescale),
    .STEP_CNT  (step_cnt),
    .GPIO_OUT  (gpio_out),
    .BUSY      (busy),
    .DONE      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pattern for step s, straight from the sequence definitions.
  function automatic logic [3:0] model_pat(input logic [1:0] m, input int s);
    logic [3:0] bounce [6];
    bounce = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    case (m)
      2'd0:    return 4'(1 << (s % 4));
      2'd1:    return bounce[s % 6];
      2'd2:    return (s % 2 == 0) ? 4'hF : 4'h0;
      default: return 4'(s % 16);
    endcase
  endfunction

  // Start a run, check every RUN cycle, the DONE cycle and the idle cycle after.
  task automatic run_check(input logic [1:0] m, input int p, input int n, input int stop_at,
                           input bit use_tab, input logic [79:0] tab, input bit scramble);
    int natural_len;
    int len;
    bit stopped;
    logic [3:0] cpu_at_edge;
    natural_len = (n != 0) ? n * (p + 1) : 0;
    len = (stop_at != 0 && (natural_len == 0 || stop_at < natural_len)) ? stop_at : natural_len;
    stopped = (len != natural_len);
    for (int k = 0; k < len; k++)
      exp_q.push_back(use_tab ? tab[4*k +: 4] : model_pat(m, k / (p + 1)));
    pat_mode  = m;
    prescale  = 16'(p);
    step_cnt  = 8'(n);
    pat_stop  = 1'b0;
    pat_start = 1'b1;
    tick();
    pat_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      check("run_gpio", gpio_out, exp_q.pop_front());
      check("run_busy", {3'b0, busy}, 4'h1);
      check("run_done", {3'b0, done}, 4'h0);
      if (scramble) begin
        pat_mode  = 2'($urandom_range(0, 3));
        prescale  = 16'($urandom_range(0, 7));
        step_cnt  = 8'($urandom_range(0, 255));
        pat_start = 1'($urandom_range(0, 1));
      end
      cpu_gpio = 4'($urandom_range(0, 15));
      if (stopped && k == len - 1) pat_stop = 1'b1;
      tick();
    end
    cpu_at_edge = cpu_gpio;
    pat_start = 1'b0;
    pat_stop  = 1'b0;
    check("end_done", {3'b0, done}, 4'h1);
    check("end_busy", {3'b0, busy}, 4'h0);
    check("end_gpio", gpio_out, cpu_at_edge);
    cpu_gpio = 4'($urandom_range(0, 15));
    cpu_at_edge = cpu_gpio;
    tick();
    check("post_done", {3'b0, done}, 4'h0);
    check("post_busy", {3'b0, busy}, 4'h0);
    check("post_gpio", gpio_out, cpu_at_edge);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          presc;
    int          steps;
    int          stop_at;
    bit          scramble;
    logic [79:0] exp_seq;
  } vec_t;

  vec_t tab [3];

  initial begin
    tab[0] = '{mode: 2'd0, presc: 1, steps: 4, stop_at: 0,  scramble: 1'b0, exp_seq: 80'h88442211};
    tab[1] = '{mode: 2'd1, presc: 0, steps: 8, stop_at: 0,  scramble: 1'b1, exp_seq: 80'h21248421};
    tab[2] = '{mode: 2'd3, presc: 0, steps: 0, stop_at: 20, scramble: 1'b0,
               exp_seq: 80'h3210_FEDCBA9876543210};

    resetn    = 1'b0;
    cpu_gpio  = 4'h5;
    pat_start = 1'b0;
    pat_stop  = 1'b0;
    pat_mode  = 2'd0;
    prescale  = 16'd0;
    step_cnt  = 8'd0;
    tick();
    tick();
    check("rst_gpio", gpio_out, 4'h0);
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_done", {3'b0, done}, 4'h0);
    resetn = 1'b1;
    tick();
    check("idle_pass", gpio_out, 4'h5);

    for (int i = 0; i < 3; i++)
      run_check(tab[i].mode, tab[i].presc, tab[i].steps, tab[i].stop_at, 1'b1, tab[i].exp_seq,
                tab[i].scramble);

    // start and stop together in IDLE: stop wins, no run
    cpu_gpio  = 4'h9;
    pat_start = 1'b1;
    pat_stop  = 1'b1;
    tick();
    check("both_busy", {3'b0, busy}, 4'h0);
    check("both_gpio", gpio_out, 4'h9);
    pat_start = 1'b0;
    tick();
    check("stop_idle_busy", {3'b0, busy}, 4'h0);
    check("stop_idle_done", {3'b0, done}, 4'h0);
    pat_stop = 1'b0;

    // level-held start restarts in the DONE cycle
    pat_mode  = 2'd0;
    prescale  = 16'd0;
    step_cnt  = 8'd2;
    cpu_gpio  = 4'h6;
    pat_start = 1'b1;
    tick();
    check("lvl_s0", gpio_out, 4'h1);
    tick();
    check("lvl_s1", gpio_out, 4'h2);
    tick();
    check("lvl_done", {3'b0, done}, 4'h1);
    check("lvl_gpio", gpio_out, 4'h6);
    tick();
    check("lvl_rebusy", {3'b0, busy}, 4'h1);
    check("lvl_re_s0", gpio_out, 4'h1);
    check("lvl_re_done", {3'b0, done}, 4'h0);
    pat_start = 1'b0;
    pat_stop  = 1'b1;
    tick();
    check("lvl_stop_done", {3'b0, done}, 4'h1);
    pat_stop = 1'b0;
    tick();

    // reset mid BLINK run: output zero, no DONE, then CPU_GPIO after release
    pat_mode  = 2'd2;
    step_cnt  = 8'd0;
    pat_start = 1'b1;
    tick();
    pat_start = 1'b0;
    check("blink_s0", gpio_out, 4'hF);
    tick();
    check("blink_s1", gpio_out, 4'h0);
    resetn = 1'b0;
    tick();
    check("mid_rst_gpio", gpio_out, 4'h0);
    check("mid_rst_busy", {3'b0, busy}, 4'h0);
    check("mid_rst_done", {3'b0, done}, 4'h0);
    cpu_gpio = 4'hA;
    tick();
    check("mid_rst_done2", {3'b0, done}, 4'h0);
    resetn = 1'b1;
    tick();
    check("rel_gpio", gpio_out, 4'hA);
    check("rel_done", {3'b0, done}, 4'h0);

    // randomized runs against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0] m;
      int p, n, s;
      m = 2'($urandom_range(0, 3));
      p = $urandom_range(0, 3);
      n = $urandom_range(0, 10);
      if (n == 0) s = $urandom_range(1, 30);
      else s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * (p + 1)) : 0;
      run_check(m, p, n, s, 1'b0, 80'h0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_out_sequencer.md
GPIO_OUT_SEQUENCER -- requirements
Module: gpio_out_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescale value.
REQ-002 SHALL have parameter STEP_W, default 8, width of the step count.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESETn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port CPU_GPIO  input  4  GPIO value from the processor subsystem.
REQ-006 SHALL have port PAT_START  input  1  request a pattern run; single-cycle pulse or level.
REQ-007 SHALL have port PAT_STOP  input  1  abort the current run.
REQ-008 SHALL have port PAT_MODE  input  2  pattern select: 0 WALK, 1 BOUNCE, 2 BLINK, 3 COUNT.
REQ-009 SHALL have port PRESCALE  input  PRESCALE_W  cycles per step minus one.
REQ-010 SHALL have port STEP_CNT  input  STEP_W  steps per run; 0 means run until stopped.
REQ-011 SHALL have port GPIO_OUT  output  4  registered board GPIO drive.
REQ-012 SHALL have port BUSY  output  1  high while a pattern owns GPIO_OUT.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse on normal completion or abort.

Function
REQ-014 SHALL implement states IDLE and RUN only.
REQ-015 SHALL, in IDLE, drive GPIO_OUT with CPU_GPIO registered, giving 1 cycle of latency.
REQ-016 SHALL accept PAT_START only in IDLE; a start sampled at edge N puts the block in RUN after edge N, with GPIO_OUT = step-0 pattern and BUSY=1.
REQ-017 SHALL latch PAT_MODE, PRESCALE and STEP_CNT at start acceptance; input changes during RUN are ignored.
REQ-018 SHALL show each step for exactly PRESCALE+1 cycles; PRESCALE=0 advances every cycle.
REQ-019 SHALL produce the WALK sequence 0001,0010,0100,1000, then repeat.
REQ-020 SHALL produce the BOUNCE sequence 0001,0010,0100,1000,0100,0010, then repeat.
REQ-021 SHALL produce the BLINK sequence 1111,0000, then repeat.
REQ-022 SHALL, in COUNT mode, output the low 4 bits of the step index, wrapping 1111 to 0000.
REQ-023 SHALL, when STEP_CNT!=0, return to IDLE at the edge that ends step STEP_CNT-1, with DONE=1 and GPIO_OUT=CPU_GPIO in that first IDLE cycle.
REQ-024 SHALL, when STEP_CNT=0, wrap the step index modulo 2^STEP_W and never self-terminate.
REQ-025 SHALL, on PAT_STOP sampled in RUN, return to IDLE at the next edge with DONE=1; PAT_STOP in IDLE has no effect.
REQ-026 SHALL give PAT_STOP priority when PAT_STOP and PAT_START are asserted together; the block stays in or enters IDLE.
REQ-027 SHALL ignore PAT_START during RUN, including in the completion cycle.
REQ-028 SHALL use a level-held PAT_START as a new start in the first IDLE cycle after DONE.

Reset
REQ-029 SHALL, while RESETn=0 at an edge, set state=IDLE, GPIO_OUT=0000, BUSY=0, DONE=0 and clear the prescaler and step counters.
REQ-030 SHALL abort a run in progress on reset without asserting DONE.

Structure
REQ-031 SHALL place the state encoding, PAT_MODE encodings and the BOUNCE lookup table in package gpio_seq_pkg.
REQ-032 SHALL implement the prescaler as sub-module gpio_seq_prescaler (inputs: load, clear, PRESCALE; output: one-cycle tick).

Verification
REQ-033 SHALL cover: WALK, PRESCALE=1, STEP_CNT=4 -> GPIO_OUT 1,1,2,2,4,4,8,8 (hex); DONE on the next cycle; then CPU_GPIO.
REQ-034 SHALL cover: BOUNCE, PRESCALE=0, STEP_CNT=8 -> 1,2,4,8,4,2,1,2, then DONE.
REQ-035 SHALL cover: COUNT, PRESCALE=0, STEP_CNT=0 run for 20 cycles, then PAT_STOP -> 0..F,0..3; DONE one cycle after stop; BUSY=0.
REQ-036 SHALL cover: PAT_START and PAT_STOP asserted together in IDLE -> no run, BUSY stays 0.
REQ-037 SHALL cover: BLINK run with RESETn pulsed low mid-run -> GPIO_OUT=0, no DONE; then CPU_GPIO=A (hex) appears 1 cycle after reset release.
REQ-038 SHALL cover: PAT_MODE and PRESCALE changed mid-run -> the output sequence is unchanged.
